// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the parametrised synchronous FIFO.
//   - read-mode constants FIFO_STD / FIFO_FWFT
//   - pointer / count / address width helpers
//   - parameter legality checks, evaluated at elaboration by param_sync_fifo
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Address bits needed to index DEPTH entries.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Count must represent 0..DEPTH inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit af_thresh_ok(input int thresh, input int depth);
    return (thresh >= 1) && (thresh <= depth);
  endfunction

  function automatic bit ae_thresh_ok(input int thresh, input int depth);
    return (thresh >= 0) && (thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port RAM, DEPTH x DATA_W.
//   clk      : clock, rising edge
//   rst_n    : async active-low reset (read register only, array is not reset)
//   wr_en    : write strobe, wr_data stored at wr_addr on the edge
//   rd_en    : load the read register from rd_addr on the edge
//   rd_data  : registered read data
// Standard mode strobes rd_en only on accepted reads; FWFT mode keeps rd_en
// high and steers rd_addr to the next head so the output tracks the head word.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read-before-write on an address collision: the old word is returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with fill count, programmable
// almost-full/almost-empty, sticky overflow/underflow and selectable
// standard or first-word-fall-through read.
//   clk, rst_n        : clock, async active-low reset
//   data_in, w_en     : write data / request (ignored while full)
//   r_en              : read request (ignored while empty)
//   clr_err           : clear sticky errors (a same-cycle error wins)
//   data_out          : read data (FWFT: head word, invalid while empty)
//   full, empty       : occupancy flags
//   almost_full/empty : count >= AF_THRESH / count <= AE_THRESH
//   count             : occupancy 0..DEPTH
//   overflow/underflow: sticky error flags
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FIFO_STD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     w_en,
  input  logic                     r_en,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = addr_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = count_w(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two and at least 2");
  end
  if (!af_thresh_ok(AF_THRESH, DEPTH)) begin : g_bad_af
    $error("param_sync_fifo: AF_THRESH must lie in 1..DEPTH");
  end
  if (!ae_thresh_ok(AE_THRESH, DEPTH)) begin : g_bad_ae
    $error("param_sync_fifo: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc;
  logic [CW-1:0] old_words;

  always_comb begin
    wr_acc   = w_en && !full_q;
    rd_acc   = r_en && !empty_q;
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(rd_acc);

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Words that were already in the RAM before this edge and survive it.
    old_words = count_q - CW'(rd_acc);

    full_d = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
             (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]);

    // FWFT: a word written on this edge reaches data_out one edge later, so
    // the output is only valid when an older word is left at the head.
    if (FWFT == FIFO_FWFT) begin
      empty_d = (old_words == '0);
    end else begin
      empty_d = (wr_ptr_d == rd_ptr_d);
    end

    af_d = (count_d >= CW'(AF_THRESH));
    ae_d = (count_d <= CW'(AE_THRESH));

    ovf_d = ovf_q;
    if (clr_err) ovf_d = 1'b0;
    if (w_en && full_q) ovf_d = 1'b1;

    udf_d = udf_q;
    if (clr_err) udf_d = 1'b0;
    if (r_en && empty_q) udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;

  // FWFT continuously prefetches the post-edge head; standard mode loads the
  // current head only when a read is accepted.
  assign mem_rd_en   = (FWFT == FIFO_FWFT) ? 1'b1 : rd_acc;
  assign mem_rd_addr = (FWFT == FIFO_FWFT) ? rd_ptr_d[AW-1:0] : rd_ptr_q[AW-1:0];

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (data_in),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .rd_data (data_out)
  );

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

  logic       clk;
  logic       rst_n;

  logic [7:0] s_din, s_dout;
  logic       s_w_en, s_r_en, s_clr;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [3:0] s_cnt;

  logic [7:0] f_din, f_dout;
  logic       f_w_en, f_r_en, f_clr;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0] f_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_q[$];
  logic [7:0] exp_d;

  param_sync_fifo #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .data_in(s_din), .w_en(s_w_en), .r_en(s_r_en),
    .clr_err(s_clr), .data_out(s_dout), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
    .overflow(s_ovf), .underflow(s_udf)
  );

  param_sync_fifo #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .data_in(f_din), .w_en(f_w_en), .r_en(f_r_en),
    .clr_err(f_clr), .data_out(f_dout), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_std_reset(input string tag);
    chk({tag, "_s_cnt"},   32'(s_cnt),   0);
    chk({tag, "_s_empty"}, 32'(s_empty), 1);
    chk({tag, "_s_full"},  32'(s_full),  0);
    chk({tag, "_s_ae"},    32'(s_ae),    1);
    chk({tag, "_s_af"},    32'(s_af),    0);
    chk({tag, "_s_ovf"},   32'(s_ovf),   0);
    chk({tag, "_s_udf"},   32'(s_udf),   0);
    chk({tag, "_s_dout"},  32'(s_dout),  0);
  endtask

  initial begin
    rst_n = 1'b1;
    s_din = '0; s_w_en = 0; s_r_en = 0; s_clr = 0;
    f_din = '0; f_w_en = 0; f_r_en = 0; f_clr = 0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk_std_reset("reset");
    chk("reset_f_empty", 32'(f_empty), 1);
    chk("reset_f_cnt",   32'(f_cnt),   0);
    chk("reset_f_dout",  32'(f_dout),  0);

    // release between edges, then the first edge already accepts a write
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---------------- standard mode: fill ----------------
    for (int i = 1; i <= 8; i++) begin
      s_w_en = 1; s_din = 8'(i);
      tick();
      $display("fill  wr=%02h cnt=%0d full=%0b af=%0b ae=%0b", s_din, s_cnt, s_full, s_af, s_ae);
      chk($sformatf("fill_cnt_%0d", i),  32'(s_cnt),  i);
      chk($sformatf("fill_af_%0d", i),   32'(s_af),   (i >= 6) ? 1 : 0);
      chk($sformatf("fill_ae_%0d", i),   32'(s_ae),   (i <= 2) ? 1 : 0);
      chk($sformatf("fill_full_%0d", i), 32'(s_full), (i == 8) ? 1 : 0);
    end

    // overflow: write 0xAA while full
    s_din = 8'hAA; s_w_en = 1;
    tick();
    $display("ovf   wr=aa cnt=%0d ovf=%0b", s_cnt, s_ovf);
    chk("ovf_cnt",  32'(s_cnt),  8);
    chk("ovf_flag", 32'(s_ovf),  1);
    chk("ovf_full", 32'(s_full), 1);

    // error in the same cycle as clr_err keeps the flag set
    s_clr = 1;
    tick();
    $display("clr+ovf ovf=%0b", s_ovf);
    chk("clr_err_wins", 32'(s_ovf), 1);
    s_w_en = 0;
    tick();
    s_clr = 0;
    $display("clr   ovf=%0b", s_ovf);
    chk("clr_ovf", 32'(s_ovf), 0);

    // ---------------- standard mode: drain ----------------
    for (int i = 1; i <= 8; i++) begin
      s_r_en = 1;
      tick();
      $display("drain rd=%02h cnt=%0d empty=%0b", s_dout, s_cnt, s_empty);
      chk($sformatf("drain_data_%0d", i), 32'(s_dout), i);
      chk($sformatf("drain_cnt_%0d", i),  32'(s_cnt),  8 - i);
    end
    chk("drain_empty", 32'(s_empty), 1);

    // underflow: read while empty, data_out holds 0x08
    tick();
    s_r_en = 0;
    $display("udf   dout=%02h udf=%0b", s_dout, s_udf);
    chk("udf_flag", 32'(s_udf),  1);
    chk("udf_hold", 32'(s_dout), 8'h08);
    chk("udf_cnt",  32'(s_cnt),  0);

    s_clr = 1;
    tick();
    s_clr = 0;
    chk("clr_udf", 32'(s_udf), 0);

    // simultaneous write/read into empty: only the write is taken
    s_w_en = 1; s_r_en = 1; s_din = 8'h11;
    tick();
    s_w_en = 0; s_r_en = 0;
    $display("both@empty cnt=%0d udf=%0b empty=%0b", s_cnt, s_udf, s_empty);
    chk("both_empty_cnt",   32'(s_cnt),   1);
    chk("both_empty_udf",   32'(s_udf),   1);
    chk("both_empty_empty", 32'(s_empty), 0);
    s_clr = 1;
    tick();
    s_clr = 0;
    s_r_en = 1;
    tick();
    s_r_en = 0;
    $display("read  rd=%02h", s_dout);
    chk("both_empty_data", 32'(s_dout), 8'h11);

    // ---------------- wrap with sustained read+write ----------------
    for (int i = 0; i < 4; i++) begin
      s_w_en = 1; s_din = 8'h21 + 8'(i);
      ref_q.push_back(s_din);
      tick();
    end
    s_w_en = 0;
    chk("wrap_pre_cnt", 32'(s_cnt), 4);
    for (int k = 0; k < 20; k++) begin
      s_w_en = 1; s_r_en = 1; s_din = 8'h40 + 8'(k);
      exp_d = ref_q.pop_front();
      ref_q.push_back(s_din);
      tick();
      $display("wrap  wr=%02h rd=%02h cnt=%0d", s_din, s_dout, s_cnt);
      chk($sformatf("wrap_data_%0d", k), 32'(s_dout), 32'(exp_d));
      chk($sformatf("wrap_cnt_%0d", k),  32'(s_cnt),  4);
    end
    s_w_en = 0;
    for (int k = 0; k < 4; k++) begin
      s_r_en = 1;
      exp_d = ref_q.pop_front();
      tick();
      $display("tail  rd=%02h cnt=%0d", s_dout, s_cnt);
      chk($sformatf("tail_data_%0d", k), 32'(s_dout), 32'(exp_d));
    end
    s_r_en = 0;
    chk("tail_empty", 32'(s_empty), 1);

    // ---------------- FWFT mode ----------------
    f_w_en = 1; f_din = 8'h5A;
    tick();
    f_w_en = 0;
    $display("fwft  wr=5a cnt=%0d empty=%0b", f_cnt, f_empty);
    chk("fwft_cnt1",      32'(f_cnt),   1);
    chk("fwft_lat_empty", 32'(f_empty), 1);
    tick();
    $display("fwft  head=%02h empty=%0b", f_dout, f_empty);
    chk("fwft_vis_empty", 32'(f_empty), 0);
    chk("fwft_vis_data",  32'(f_dout),  8'h5A);
    f_w_en = 1; f_din = 8'h6B;
    tick();
    f_din = 8'h7C;
    tick();
    f_w_en = 0;
    chk("fwft_head_hold", 32'(f_dout), 8'h5A);
    f_r_en = 1;
    tick();
    $display("fwft  rd head=%02h cnt=%0d", f_dout, f_cnt);
    chk("fwft_next1",   32'(f_dout), 8'h6B);
    chk("fwft_cnt_rd1", 32'(f_cnt),  2);
    tick();
    $display("fwft  rd head=%02h cnt=%0d", f_dout, f_cnt);
    chk("fwft_next2",   32'(f_dout), 8'h7C);
    tick();
    $display("fwft  rd empty=%0b cnt=%0d", f_empty, f_cnt);
    chk("fwft_empty_end", 32'(f_empty), 1);
    chk("fwft_cnt_end",   32'(f_cnt),   0);
    tick();
    f_r_en = 0;
    chk("fwft_udf", 32'(f_udf), 1);

    // ---------------- async reset mid-burst ----------------
    for (int i = 0; i < 5; i++) begin
      s_w_en = 1; s_din = 8'h90 + 8'(i);
      tick();
    end
    chk("mid_cnt5", 32'(s_cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    $display("async rst cnt=%0d empty=%0b dout=%02h", s_cnt, s_empty, s_dout);
    chk_std_reset("async");
    chk("async_f_udf", 32'(f_udf), 0);
    tick();
    tick();
    s_w_en = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_w_en = 1; s_din = 8'h33;
    tick();
    s_w_en = 0; s_r_en = 1;
    tick();
    s_r_en = 0;
    $display("post  rd=%02h cnt=%0d", s_dout, s_cnt);
    chk("post_rst_data", 32'(s_dout), 8'h33);
    chk("post_rst_cnt",  32'(s_cnt),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
